jump_ctrl: RTL and testbench

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/jump_ctrl_if.sv | 26 ++
 rtl/jump_ctrl.sv | 136 +++++++++++++
 tb/tb_jump_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/jump_ctrl_if.sv
// Player-controller bundle: button/collision inputs toward the jump FSM and the
// registered velocity/charge/state outputs coming back from it.
interface jump_ctrl_if;
    logic              tick;
    logic              left;
    logic              right;
    logic              jump;
    logic              on_ground;
    logic              wall_hit;
    logic              ceil_hit;
    logic signed [7:0] vel_x;
    logic signed [7:0] vel_y;
    logic        [4:0] charge;
    logic        [2:0] state;
    logic              launch;

    modport master (
        output tick, left, right, jump, on_ground, wall_hit, ceil_hit,
        input  vel_x, vel_y, charge, state, launch
    );

    modport slave (
        input  tick, left, right, jump, on_ground, wall_hit, ceil_hit,
        output vel_x, vel_y, charge, state, launch
    );
endinterface

// File: rtl/jump_ctrl.sv
// Charge-and-release jump controller: walk, charge, launch, airborne physics
// and landing, all stepped by the physics tick strobe.
module jump_ctrl #(
    parameter int WALK_V     = 2,
    parameter int VX_JUMP    = 3,
    parameter int VY_BASE    = 4,
    parameter int CHARGE_MAX = 31,
    parameter int GRAVITY    = 1,
    parameter int VY_TERM    = 12
) (
    input logic        sys_clk,
    input logic        sys_rst_n,
    jump_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        LAUNCH = 3'd2,
        AIR    = 3'd3,
        LAND   = 3'd4
    } state_t;

    localparam logic [4:0] CMAX = 5'(CHARGE_MAX);

    state_t            state_q, state_n;
    logic signed [7:0] vel_x_q, vel_x_n;
    logic signed [7:0] vel_y_q, vel_y_n;
    logic        [4:0] charge_q, charge_n;
    logic signed [1:0] dir_q, dir_n;
    logic              armed_q, armed_n;
    logic              launch_q, launch_n;

    // All velocity math is done in 32-bit ints and clamped, so nothing wraps.
    function automatic logic signed [7:0] sat8(input int v);
        if (v > 127)       sat8 = 8'h7f;
        else if (v < -128) sat8 = 8'h80;
        else               sat8 = 8'(v);
    endfunction

    function automatic logic signed [7:0] fall(input logic signed [7:0] v);
        int s;
        s = int'(v) + GRAVITY;
        if (s > VY_TERM) s = VY_TERM;
        fall = sat8(s);
    endfunction

    function automatic logic signed [7:0] walk(input logic l, input logic r);
        if (r && !l)      walk = sat8(WALK_V);
        else if (l && !r) walk = sat8(-WALK_V);
        else              walk = 8'sd0;
    endfunction

    always_comb begin
        state_n  = state_q;
        vel_x_n  = vel_x_q;
        vel_y_n  = vel_y_q;
        charge_n = charge_q;
        dir_n    = dir_q;
        armed_n  = armed_q;
        launch_n = 1'b0;
        if (bus.tick) begin
            if (!bus.jump) armed_n = 1'b1;
            case (state_q)
                IDLE: begin
                    vel_y_n = 8'sd0;
                    // Walking off a ledge beats starting a charge.
                    if (!bus.on_ground) begin
                        state_n = AIR;
                    end else if (bus.jump && armed_q) begin
                        state_n  = CHARGE;
                        charge_n = 5'd0;
                        vel_x_n  = 8'sd0;
                        dir_n    = 2'sd0;
                    end else begin
                        vel_x_n = walk(bus.left, bus.right);
                    end
                end
                CHARGE: begin
                    charge_n = (charge_q == CMAX) ? CMAX : charge_q + 5'd1;
                    if (bus.right && !bus.left)      dir_n = 2'sb01;
                    else if (bus.left && !bus.right) dir_n = 2'sb11;
                    vel_x_n = 8'sd0;
                    vel_y_n = 8'sd0;
                    if (!bus.jump || charge_q == CMAX) state_n = LAUNCH;
                end
                LAUNCH: begin
                    vel_y_n  = sat8(-(VY_BASE + int'(charge_q)));
                    vel_x_n  = sat8(int'(dir_q) * VX_JUMP);
                    charge_n = 5'd0;
                    // Clearing wins over a released button on this tick.
                    armed_n  = 1'b0;
                    launch_n = 1'b1;
                    state_n  = AIR;
                end
                AIR: begin
                    if (bus.wall_hit) vel_x_n = sat8(-int'(vel_x_q));
                    if (bus.on_ground && !vel_y_q[7])   state_n = LAND;
                    else if (bus.ceil_hit && vel_y_q[7]) vel_y_n = 8'sd0;
                    else                                 vel_y_n = fall(vel_y_q);
                end
                LAND: begin
                    vel_x_n = 8'sd0;
                    vel_y_n = 8'sd0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            vel_x_q  <= 8'sd0;
            vel_y_q  <= 8'sd0;
            charge_q <= 5'd0;
            dir_q    <= 2'sd0;
            armed_q  <= 1'b1;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            vel_x_q  <= vel_x_n;
            vel_y_q  <= vel_y_n;
            charge_q <= charge_n;
            dir_q    <= dir_n;
            armed_q  <= armed_n;
            launch_q <= launch_n;
        end
    end

    assign bus.vel_x  = vel_x_q;
    assign bus.vel_y  = vel_y_q;
    assign bus.charge = charge_q;
    assign bus.state  = state_q;
    assign bus.launch = launch_q;
endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: directed scenarios plus a randomized run against an
// integer-level model of the jump rules.
module tb_jump_ctrl;
    localparam int WALK_V = 2, VX_JUMP = 3, VY_BASE = 4, CHARGE_MAX = 31, GRAVITY = 1, VY_TERM = 12;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    jump_ctrl_if bus();

    jump_ctrl #(.WALK_V(WALK_V), .VX_JUMP(VX_JUMP), .VY_BASE(VY_BASE), .CHARGE_MAX(CHARGE_MAX),
                .GRAVITY(GRAVITY), .VY_TERM(VY_TERM))
        dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_total = 0;

    // Model state: 0 idle, 1 charge, 2 launch, 3 air, 4 land.
    int m_st, m_vx, m_vy, m_ch, m_dir;
    bit m_arm, m_launch;

    function automatic int clamp8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    task automatic model_reset();
        m_st = 0; m_vx = 0; m_vy = 0; m_ch = 0; m_dir = 0; m_arm = 1'b1; m_launch = 1'b0;
    endtask

    task automatic model_tick(input bit t, l, r, j, g, w, c);
        int ns, nvx, nvy, nch, ndir;
        bit narm;
        ns = m_st; nvx = m_vx; nvy = m_vy; nch = m_ch; ndir = m_dir; narm = m_arm;
        m_launch = t && (m_st == 2);
        if (t) begin
            if (!j) narm = 1'b1;
            if (m_st == 0) begin
                nvy = 0;
                if (!g) ns = 3;
                else if (j && m_arm) begin ns = 1; nch = 0; nvx = 0; ndir = 0; end
                else nvx = (r && !l) ? WALK_V : ((l && !r) ? -WALK_V : 0);
            end else if (m_st == 1) begin
                nch = (m_ch + 1 > CHARGE_MAX) ? CHARGE_MAX : m_ch + 1;
                if (r && !l) ndir = 1; else if (l && !r) ndir = -1;
                nvx = 0; nvy = 0;
                if (!j || m_ch == CHARGE_MAX) ns = 2;
            end else if (m_st == 2) begin
                nvy = clamp8(-(VY_BASE + m_ch));
                nvx = clamp8(m_dir * VX_JUMP);
                nch = 0; narm = 1'b0; ns = 3;
            end else if (m_st == 3) begin
                if (w) nvx = clamp8(-m_vx);
                if (g && m_vy >= 0) ns = 4;
                else if (c && m_vy < 0) nvy = 0;
                else nvy = clamp8((m_vy + GRAVITY > VY_TERM) ? VY_TERM : m_vy + GRAVITY);
            end else begin
                nvx = 0; nvy = 0; ns = 0;
            end
        end
        m_st = ns; m_vx = nvx; m_vy = nvy; m_ch = nch; m_dir = ndir; m_arm = narm;
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance model, sample at posedge+1.
    task automatic step(input bit t, l, r, j, g, w, c);
        bus.tick = t; bus.left = l; bus.right = r; bus.jump = j;
        bus.on_ground = g; bus.wall_hit = w; bus.ceil_hit = c;
        model_tick(t, l, r, j, g, w, c);
        @(posedge sys_clk); #1;
        bus.tick = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #2;
        bus.tick = 0; bus.left = 0; bus.right = 0; bus.jump = 0;
        bus.on_ground = 1; bus.wall_hit = 0; bus.ceil_hit = 0;
        sys_rst_n = 1'b0;
        model_reset();
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_total++; if (bus.state !== 3'd0) $display("FAIL reset_state got %0d exp 0", bus.state); else n_pass++;
        n_total++; if (bus.vel_x !== 8'd0) $display("FAIL reset_vx got %0d exp 0", bus.vel_x); else n_pass++;
        n_total++; if (bus.vel_y !== 8'd0) $display("FAIL reset_vy got %0d exp 0", bus.vel_y); else n_pass++;
        n_total++; if (bus.charge !== 5'd0) $display("FAIL reset_charge got %0d exp 0", bus.charge); else n_pass++;
        n_total++; if (bus.launch !== 1'b0) $display("FAIL reset_launch got %0d exp 0", bus.launch); else n_pass++;
        @(negedge sys_clk) sys_rst_n = 1'b1;
        model_reset();
        @(posedge sys_clk); #1;
    endtask

    task automatic test_walk();
        do_reset();
        repeat (3) step(1, 0, 1, 0, 1, 0, 0);
        n_total++; if (bus.vel_x !== 8'(2)) $display("FAIL walk_right_vx got %0d exp 2", $signed(bus.vel_x)); else n_pass++;
        n_total++; if (bus.vel_y !== 8'(0)) $display("FAIL walk_right_vy got %0d exp 0", $signed(bus.vel_y)); else n_pass++;
        n_total++; if (bus.state !== 3'd0) $display("FAIL walk_right_state got %0d exp 0", bus.state); else n_pass++;
        step(1, 1, 0, 0, 1, 0, 0);
        n_total++; if (bus.vel_x !== 8'(-2)) $display("FAIL walk_left_vx got %0d exp -2", $signed(bus.vel_x)); else n_pass++;
        step(1, 1, 1, 0, 1, 0, 0);
        n_total++; if (bus.vel_x !== 8'(0)) $display("FAIL walk_both_vx got %0d exp 0", $signed(bus.vel_x)); else n_pass++;
        step(1, 0, 1, 0, 1, 0, 0);
        repeat (3) step(0, 1, 0, 1, 0, 1, 1);
        n_total++; if (bus.vel_x !== 8'(2) || bus.state !== 3'd0)
            $display("FAIL no_tick_hold got vx=%0d st=%0d exp vx=2 st=0", $signed(bus.vel_x), bus.state); else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.state !== 3'd3 || bus.vel_x !== 8'(2) || bus.vel_y !== 8'(0))
            $display("FAIL ledge got st=%0d vx=%0d vy=%0d exp st=3 vx=2 vy=0", bus.state, $signed(bus.vel_x), $signed(bus.vel_y)); else n_pass++;
    endtask

    task automatic test_charge_release();
        do_reset();
        repeat (11) step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd1 || bus.charge !== 5'd10)
            $display("FAIL charging got st=%0d ch=%0d exp st=1 ch=10", bus.state, bus.charge); else n_pass++;
        step(1, 0, 1, 0, 1, 0, 0);
        n_total++; if (bus.state !== 3'd2 || bus.charge !== 5'd11)
            $display("FAIL release got st=%0d ch=%0d exp st=2 ch=11", bus.state, bus.charge); else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.state !== 3'd3 || bus.vel_y !== 8'(-15) || bus.vel_x !== 8'(3) || bus.charge !== 5'd0)
            $display("FAIL launch_vel got st=%0d vx=%0d vy=%0d ch=%0d exp 3/3/-15/0", bus.state, $signed(bus.vel_x), $signed(bus.vel_y), bus.charge); else n_pass++;
        n_total++; if (bus.launch !== 1'b1) $display("FAIL launch_pulse got %0d exp 1", bus.launch); else n_pass++;
        step(0, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.launch !== 1'b0) $display("FAIL launch_once got %0d exp 0", bus.launch); else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.vel_y !== 8'(-14)) $display("FAIL gravity1 got %0d exp -14", $signed(bus.vel_y)); else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.vel_y !== 8'(-13)) $display("FAIL gravity2 got %0d exp -13", $signed(bus.vel_y)); else n_pass++;
        repeat (30) step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.vel_y !== 8'(12)) $display("FAIL terminal got %0d exp 12", $signed(bus.vel_y)); else n_pass++;
        step(1, 0, 0, 0, 1, 0, 0);
        n_total++; if (bus.state !== 3'd4 || bus.vel_y !== 8'(12))
            $display("FAIL land_enter got st=%0d vy=%0d exp st=4 vy=12", bus.state, $signed(bus.vel_y)); else n_pass++;
        step(1, 0, 1, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd0 || bus.vel_x !== 8'(0) || bus.vel_y !== 8'(0))
            $display("FAIL land_exit got st=%0d vx=%0d vy=%0d exp 0/0/0", bus.state, $signed(bus.vel_x), $signed(bus.vel_y)); else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (32) step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd1 || bus.charge !== 5'd31)
            $display("FAIL sat_charge got st=%0d ch=%0d exp st=1 ch=31", bus.state, bus.charge); else n_pass++;
        step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd2 || bus.charge !== 5'd31)
            $display("FAIL auto_launch got st=%0d ch=%0d exp st=2 ch=31", bus.state, bus.charge); else n_pass++;
        step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.vel_y !== 8'(-35) || bus.vel_x !== 8'(0))
            $display("FAIL sat_launch got vx=%0d vy=%0d exp 0/-35", $signed(bus.vel_x), $signed(bus.vel_y)); else n_pass++;
        for (int i = 0; i < 80 && bus.state !== 3'd4; i++) step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd4) $display("FAIL land_timeout got st=%0d exp 4", bus.state); else n_pass++;
        repeat (4) step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd0) $display("FAIL no_recharge got st=%0d exp 0", bus.state); else n_pass++;
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.state !== 3'd1) $display("FAIL rearm got st=%0d exp 1", bus.state); else n_pass++;
    endtask

    task automatic test_air_bounce();
        do_reset();
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.vel_x !== 8'(3) || bus.vel_y !== 8'(-5))
            $display("FAIL bounce_setup got vx=%0d vy=%0d exp 3/-5", $signed(bus.vel_x), $signed(bus.vel_y)); else n_pass++;
        step(1, 0, 0, 0, 0, 1, 1);
        n_total++; if (bus.vel_x !== 8'(-3) || bus.vel_y !== 8'(0))
            $display("FAIL wall_ceil got vx=%0d vy=%0d exp -3/0", $signed(bus.vel_x), $signed(bus.vel_y)); else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0);
        n_total++; if (bus.vel_y !== 8'(1)) $display("FAIL after_ceil got %0d exp 1", $signed(bus.vel_y)); else n_pass++;
        step(1, 0, 0, 0, 0, 1, 1);
        n_total++; if (bus.vel_y !== 8'(2) || bus.vel_x !== 8'(3))
            $display("FAIL ceil_falling got vx=%0d vy=%0d exp 3/2", $signed(bus.vel_x), $signed(bus.vel_y)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) step(1, 0, 0, 1, 1, 0, 0);
        n_total++; if (bus.charge !== 5'd4) $display("FAIL pre_reset_charge got %0d exp 4", bus.charge); else n_pass++;
        #2 sys_rst_n = 1'b0;
        #1;
        n_total++; if (bus.state !== 3'd0 || bus.charge !== 5'd0)
            $display("FAIL async_reset got st=%0d ch=%0d exp 0/0", bus.state, bus.charge); else n_pass++;
        sys_rst_n = 1'b1;
        model_reset();
        @(posedge sys_clk); #1;
        step(1, 0, 1, 0, 1, 0, 0);
        n_total++; if (bus.state !== 3'd0 || bus.vel_x !== 8'(2))
            $display("FAIL post_reset_idle got st=%0d vx=%0d exp 0/2", bus.state, $signed(bus.vel_x)); else n_pass++;
    endtask

    task automatic test_random();
        bit t, l, r, j, g, w, c;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom % 4) != 0;
            l = $urandom % 2; r = $urandom % 2;
            j = ($urandom % 3) != 0;
            g = ($urandom % 5) != 0;
            w = ($urandom % 6) == 0; c = ($urandom % 6) == 0;
            step(t, l, r, j, g, w, c);
            n_total++; if (bus.state !== 3'(m_st)) begin if (bad++ < 10) $display("FAIL rnd_state @%0d got %0d exp %0d", i, bus.state, m_st); end else n_pass++;
            n_total++; if (bus.vel_x !== 8'(m_vx)) begin if (bad++ < 10) $display("FAIL rnd_vx @%0d got %0d exp %0d", i, $signed(bus.vel_x), m_vx); end else n_pass++;
            n_total++; if (bus.vel_y !== 8'(m_vy)) begin if (bad++ < 10) $display("FAIL rnd_vy @%0d got %0d exp %0d", i, $signed(bus.vel_y), m_vy); end else n_pass++;
            n_total++; if (bus.charge !== 5'(m_ch)) begin if (bad++ < 10) $display("FAIL rnd_charge @%0d got %0d exp %0d", i, bus.charge, m_ch); end else n_pass++;
            n_total++; if (bus.launch !== m_launch) begin if (bad++ < 10) $display("FAIL rnd_launch @%0d got %0d exp %0d", i, bus.launch, m_launch); end else n_pass++;
        end
    endtask

    initial begin
        bus.tick = 0; bus.left = 0; bus.right = 0; bus.jump = 0;
        bus.on_ground = 1; bus.wall_hit = 0; bus.ceil_hit = 0;
        model_reset();
        test_reset();
        test_walk();
        test_charge_release();
        test_saturate();
        test_air_bounce();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
